// File: rtl/fp_mult_pipe.sv
// ---------------------------------------------------------------------------
// fp_mult_pipe
//   Fully pipelined IEEE-754 binary floating-point multiplier with generic
//   exponent/fraction widths, valid/ready flow control, DAZ/FTZ handling,
//   special-value handling and exponent range detection. Four register stages
//   (unpack, multiply, normalise, round/output), latency 4, throughput 1.
//
//   Build option: define FPMULT_RNE_EN for round-to-nearest-even; leave it
//   undefined for round-toward-zero (overflow then saturates to max finite).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  operands accepted this cycle
//   a, b       in   operands {sign, exponent, fraction}
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  product, same packing as operands
//   flags      out  {invalid, divzero, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;   // full significand product width
  localparam int EW = EXP_W + 2;       // signed working exponent width

  localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic signed [EW-1:0]  E_TOP    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  E_ZERO   = '0;

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high. One advance enable moves the whole pipeline; it is low only when
  // the output register holds a result the consumer has not taken, so every
  // stage (bubbles included) freezes together and nothing is lost or repeated.
  logic adv;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // {zero, inf, nan, snan}; exponent 0 counts as zero (subnormals flushed).
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic ones, fz;
    ones = (x[W-2:MAN_W] == EXP_ONES);
    fz   = (x[MAN_W-1:0] == '0);
    return {(x[W-2:MAN_W] == '0), ones & fz, ones & ~fz, ones & ~fz & ~x[MAN_W-1]};
  endfunction

  logic [3:0] cls_a, cls_b;
  assign cls_a = classify(a);
  assign cls_b = classify(b);

  // Stage 1: unpacked operands and combined classes
  logic             s1_v_q, s1_sgn_q, s1_zero_q, s1_inf_q, s1_nan_q, s1_snan_q;
  logic [EXP_W-1:0] s1_ea_q, s1_eb_q;
  logic [MAN_W:0]   s1_ma_q, s1_mb_q;
  // Stage 2: raw product and exponent sum
  logic             s2_v_q, s2_sgn_q, s2_zero_q, s2_inf_q, s2_nan_q, s2_snan_q;
  logic signed [EW-1:0] s2_e_q, s2_e_d;
  logic [PW-1:0]    s2_p_q, s2_p_d;
  // Stage 3: normalised fraction with guard and sticky
  logic             s3_v_q, s3_sgn_q, s3_zero_q, s3_inf_q, s3_nan_q, s3_snan_q;
  logic signed [EW-1:0] s3_e_q, s3_e_d;
  logic [MAN_W-1:0] s3_frac_q;
  logic             s3_g_q, s3_st_q;
  logic [PW-2:0]    norm;
  // Stage 4: output register
  logic             out_v_q;
  logic [W-1:0]     res_q, res_d;
  logic [4:0]       flg_q, flg_d;

  assign s2_e_d = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - $signed(EW'(BIAS));
  assign s2_p_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  // Product of two [1,2) significands lies in [1,4); drop the leading one.
  assign norm   = s2_p_q[PW-1] ? s2_p_q[PW-2:0] : {s2_p_q[PW-3:0], 1'b0};
  assign s3_e_d = s2_e_q + EW'(s2_p_q[PW-1]);

  logic signed [EW-1:0] e_r;
  logic [MAN_W-1:0]     frac_r;
  logic                 ovf, unf, inx;

`ifdef FPMULT_RNE_EN
  logic           rnd_up;
  logic [MAN_W:0] frac_ext;
  assign rnd_up   = s3_g_q & (s3_st_q | s3_frac_q[0]);
  assign frac_ext = {1'b0, s3_frac_q} + (MAN_W+1)'(rnd_up);
  // Carry out of the fraction means the significand became 2.0.
  assign e_r      = frac_ext[MAN_W] ? s3_e_q + EW'(1) : s3_e_q;
  assign frac_r   = frac_ext[MAN_W] ? '0 : frac_ext[MAN_W-1:0];
`else
  assign e_r      = s3_e_q;
  assign frac_r   = s3_frac_q;
`endif

  assign ovf = (e_r >= E_TOP);
  assign unf = (e_r <= E_ZERO);
  assign inx = s3_g_q | s3_st_q;

  always_comb begin
    res_d = {s3_sgn_q, e_r[EXP_W-1:0], frac_r};
    flg_d = {4'b0000, inx};
    if (ovf) begin
`ifdef FPMULT_RNE_EN
      res_d = {s3_sgn_q, EXP_ONES, {MAN_W{1'b0}}};
`else
      res_d = {s3_sgn_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
      flg_d = 5'b00101;
    end else if (unf) begin
      res_d = {s3_sgn_q, {(W-1){1'b0}}};
      flg_d = 5'b00011;
    end
    // Special operands override the numeric path, highest priority first.
    if (s3_nan_q) begin
      res_d = QNAN;
      flg_d = {s3_snan_q, 4'b0000};
    end else if (s3_inf_q && s3_zero_q) begin
      res_d = QNAN;
      flg_d = 5'b10000;
    end else if (s3_inf_q) begin
      res_d = {s3_sgn_q, EXP_ONES, {MAN_W{1'b0}}};
      flg_d = 5'b00000;
    end else if (s3_zero_q) begin
      res_d = {s3_sgn_q, {(W-1){1'b0}}};
      flg_d = 5'b00000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0; s1_sgn_q <= 1'b0; s1_zero_q <= 1'b0; s1_inf_q <= 1'b0;
      s1_nan_q <= 1'b0; s1_snan_q <= 1'b0; s1_ea_q <= '0; s1_eb_q <= '0;
      s1_ma_q <= '0; s1_mb_q <= '0;
      s2_v_q <= 1'b0; s2_sgn_q <= 1'b0; s2_zero_q <= 1'b0; s2_inf_q <= 1'b0;
      s2_nan_q <= 1'b0; s2_snan_q <= 1'b0; s2_e_q <= '0; s2_p_q <= '0;
      s3_v_q <= 1'b0; s3_sgn_q <= 1'b0; s3_zero_q <= 1'b0; s3_inf_q <= 1'b0;
      s3_nan_q <= 1'b0; s3_snan_q <= 1'b0; s3_e_q <= '0; s3_frac_q <= '0;
      s3_g_q <= 1'b0; s3_st_q <= 1'b0;
      out_v_q <= 1'b0; res_q <= '0; flg_q <= '0;
    end else if (adv) begin
      s1_v_q    <= in_valid;
      s1_sgn_q  <= a[W-1] ^ b[W-1];
      s1_zero_q <= cls_a[3] | cls_b[3];
      s1_inf_q  <= cls_a[2] | cls_b[2];
      s1_nan_q  <= cls_a[1] | cls_b[1];
      s1_snan_q <= cls_a[0] | cls_b[0];
      s1_ea_q   <= a[W-2:MAN_W];
      s1_eb_q   <= b[W-2:MAN_W];
      s1_ma_q   <= {1'b1, a[MAN_W-1:0]};
      s1_mb_q   <= {1'b1, b[MAN_W-1:0]};

      s2_v_q    <= s1_v_q;
      s2_sgn_q  <= s1_sgn_q;
      s2_zero_q <= s1_zero_q;
      s2_inf_q  <= s1_inf_q;
      s2_nan_q  <= s1_nan_q;
      s2_snan_q <= s1_snan_q;
      s2_e_q    <= s2_e_d;
      s2_p_q    <= s2_p_d;

      s3_v_q    <= s2_v_q;
      s3_sgn_q  <= s2_sgn_q;
      s3_zero_q <= s2_zero_q;
      s3_inf_q  <= s2_inf_q;
      s3_nan_q  <= s2_nan_q;
      s3_snan_q <= s2_snan_q;
      s3_e_q    <= s3_e_d;
      s3_frac_q <= norm[PW-2 -: MAN_W];
      s3_g_q    <= norm[PW-2-MAN_W];
      s3_st_q   <= |norm[PW-3-MAN_W:0];

      out_v_q   <= s3_v_q;
      res_q     <= res_d;
      flg_q     <= flg_d;
    end
  end

  assign out_valid = out_v_q;
  assign result    = res_q;
  assign flags     = flg_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_mult_pipe
//   Self-checking bench for fp_mult_pipe at its default (binary16) size.
//   Expected results come from directed constants or from a real-arithmetic
//   reference model; a scoreboard queue holds {result, flags} in acceptance
//   order and is compared whenever an output is retired.
// ---------------------------------------------------------------------------
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] popped;
  bit          rand_done;
  int          lat;

  fp_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact product via integer significands, rounding decided on
  // the real-valued remainder of the scaled significand.
  function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
    logic s;
    int   ex, ey, fx, fy, m, lg, be, sig_i;
    real  sig, rem;
    bit   nx, ny, inexact;
    logic [4:0] be5;
    logic [9:0] f10;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]); fx = int'(x[9:0]);
    ey = int'(y[14:10]); fy = int'(y[9:0]);
    nx = (ex == 31) && (fx != 0);
    ny = (ey == 31) && (fy != 0);
    if (nx || ny)
      return {16'h7E00, (nx && !x[9]) || (ny && !y[9]), 4'b0000};
    if (((ex == 31) && (ey == 0)) || ((ey == 31) && (ex == 0)))
      return {16'h7E00, 5'b10000};
    if ((ex == 31) || (ey == 31))
      return {s, 15'h7C00, 5'b00000};
    if ((ex == 0) || (ey == 0))
      return {s, 15'h0000, 5'b00000};
    m  = (1024 + fx) * (1024 + fy);
    lg = 0;
    while ((m >> (lg + 1)) != 0) lg++;
    be    = ex + ey - 35 + lg;
    sig   = real'(m) / (2.0 ** (lg - 10));
    sig_i = $rtoi(sig);
    rem   = sig - real'(sig_i);
    inexact = (rem != 0.0);
`ifdef FPMULT_RNE_EN
    if ((rem > 0.5) || ((rem == 0.5) && (sig_i % 2 == 1))) sig_i++;
    if (sig_i == 2048) begin sig_i = 1024; be++; end
    if (be >= 31) return {s, 15'h7C00, 5'b00101};
`else
    if (be >= 31) return {s, 15'h7BFF, 5'b00101};
`endif
    if (be <= 0) return {s, 15'h0000, 5'b00011};
    be5 = be[4:0];
    f10 = sig_i[9:0];
    return {s, be5, f10, 4'b0000, inexact};
  endfunction

  function automatic logic [15:0] rand_op();
    int k;
    logic s;
    logic [4:0] e;
    logic [9:0] f;
    k = $urandom_range(0, 99);
    s = 1'($urandom_range(0, 1));
    f = 10'($urandom_range(0, 1023));
    if (k < 70)      e = 5'($urandom_range(8, 22));
    else if (k < 80) e = 5'($urandom_range(1, 30));
    else if (k < 85) begin e = 5'd0; f = 10'd0; end
    else if (k < 88) begin e = 5'd0; f = 10'($urandom_range(1, 1023)); end
    else if (k < 92) begin e = 5'd31; f = 10'd0; end
    else if (k < 96) begin e = 5'd31; f = 10'($urandom_range(512, 1023)); end
    else             begin e = 5'd31; f = 10'($urandom_range(1, 511)); end
    return {s, e, f};
  endfunction

  // driver: present operands from posedge+1, record expectation at the
  // negedge before the accepting edge
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [20:0] e);
    int guard;
    guard = 0;
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    check("accept_timeout", in_ready, 1'b1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] x, input logic [15:0] y);
    send(x, y, model(x, y));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin @(posedge clk); guard++; end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard: compare every retired result against the head of exp_q
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        check("sb_result", result, popped[20:5]);
        check("sb_flags", flags, popped[4:0]);
      end
    end
  end

  initial begin
    // reset
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", flags, 5'b00000);
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // latency of 1.0 * 1.5
    a = 16'h3C00; b = 16'h3E00; in_valid = 1'b1;
    check("lat_in_ready", in_ready, 1'b1);
    exp_q.push_back({16'h3E00, 5'b00000});
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    check("latency", lat, 4);
    drain();

    // directed values
`ifdef FPMULT_RNE_EN
    send(16'h3C01, 16'h3E00, {16'h3E02, 5'b00001});
    send(16'h7BFF, 16'h7BFF, {16'h7C00, 5'b00101});
`else
    send(16'h3C01, 16'h3E00, {16'h3E01, 5'b00001});
    send(16'h7BFF, 16'h7BFF, {16'h7BFF, 5'b00101});
`endif
    send(16'h7C00, 16'h8000, {16'h7E00, 5'b10000});
    send(16'h7D00, 16'h3C00, {16'h7E00, 5'b10000});
    send(16'h0400, 16'h0400, {16'h0000, 5'b00011});
    send(16'h7E00, 16'h7C00, {16'h7E00, 5'b00000});
    send(16'h7C00, 16'hC000, {16'hFC00, 5'b00000});
    send(16'h8000, 16'h3C00, {16'h8000, 5'b00000});
    send(16'h0001, 16'h3C00, {16'h0000, 5'b00000});
    send(16'hC000, 16'h4200, {16'hC600, 5'b00000});
    drain();

    // back-pressure: 8 operations, output held for ten cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(16'h3C00 + 16'(i * 37), rand_op());
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 1'b0);
          check("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with three operations in flight
    out_ready = 1'b0;
    send_model(rand_op(), rand_op());
    send_model(rand_op(), rand_op());
    send_model(rand_op(), rand_op());
    @(posedge clk); #1;
    check("mid_rst_pre_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_stale", out_valid, 1'b0);
    send(16'h4000, 16'h4000, {16'h4400, 5'b00000});
    drain();

    // random traffic with random stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_model(rand_op(), rand_op());
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 binary floating-point multiplier. Successor to the fixed-width fp16 multiplier.
- Exponent and mantissa widths are generic.
- Contains its own mantissa multiplier.
- Adds valid/ready flow control with back-pressure, correct special-value handling, exponent overflow/underflow detection and round-to-nearest-even.
- Sits between operand-issue logic and the DSP-slice accumulate path.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width (hidden bit excluded).
- BIAS, 15, exponent bias. Must equal 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  1+EXP_W+MAN_W  operand A, packed {sign, exponent, fraction}.
- b  in  1+EXP_W+MAN_W  operand B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+MAN_W  product.
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}.

Behaviour:
- Reset (rst low, asynchronous): all stage valids clear; out_valid=0, result=0, flags=0. in_ready=1 once rst is released.
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv. Transfer occurs when in_valid & in_ready. When adv=0 every stage register holds.
- Four register stages; latency is exactly 4 cycles with no stall:
  - S1: unpack/classify (zero, sub, inf, nan, snan = nan with fraction MSB 0).
  - S2: (MAN_W+1)x(MAN_W+1) unsigned product; exponent sum E = Ea+Eb-BIAS, signed, EXP_W+2 bits; sign = Sa^Sb.
  - S3: normalise. If product MSB is 1, shift right 1 and E+1. Then form kept fraction, G, and sticky = OR of the remaining bits.
  - S4: round, range check, special override; this is the output register.
- Throughput 1/cycle. Up to 4 operations in flight. Bubbles are carried, not compressed.
- Result ordering equals acceptance order. No drop or duplication under any out_ready pattern.
- Subnormal inputs are treated as signed zero (DAZ). No subnormal outputs are produced (FTZ).
- Rounding (RNE): up = G & (sticky | LSB). A carry out of the fraction increments E and clears the fraction.
- Overflow: E >= 2^EXP_W-1 after rounding gives ±inf, flags overflow=1, inexact=1.
- Underflow: E <= 0 after rounding with a nonzero product gives ±0, flags underflow=1, inexact=1.
- Inexact: set when G|sticky is nonzero, or on overflow/underflow.
- Special-value priority (highest first):
  1. Any NaN input gives canonical qNaN {0, all-ones exponent, 1, 0...}. invalid=1 if either input is an sNaN.
  2. inf*zero gives canonical qNaN, invalid=1.
  3. inf*finite gives ±inf, no flags.
  4. zero*finite gives ±0, no flags.
- divzero flag is always 0.
- rst asserted mid-stream: all in-flight operations are discarded. The first out_valid after release corresponds to the first post-release acceptance.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the output retires and the new operand enters S1 in the same edge.

Optional Feature:
- Macro: FPMULT_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: round toward zero. Fraction is truncated, so G and sticky only drive the inexact flag.
- Undefined, overflow: gives ±max finite {s, 2^EXP_W-2, all-ones} with overflow=1 and inexact=1, instead of ±inf.
- All other behaviour is identical in both builds.

Test Plan:
- 0x3C00 * 0x3E00 (1.0*1.5) -> result 0x3E00, flags 5'b00000, out_valid exactly 4 cycles after acceptance.
- Tie case 0x3C01 * 0x3E00 -> 0x3E02, flags 5'b00001 with FPMULT_RNE_EN. Without the macro -> 0x3E01, flags 5'b00001.
- 0x7BFF * 0x7BFF -> 0x7C00, flags 5'b00101 (RNE). Without the macro -> 0x7BFF, flags 5'b00101.
- 0x7C00 * 0x8000 -> 0x7E00, flags 5'b10000. 0x7D00 (sNaN) * 0x3C00 -> 0x7E00, flags 5'b10000. 0x0400 * 0x0400 -> 0x0000, flags 5'b00011.
- Back-pressure:
  - Stimulus: stream 8 distinct operand pairs; hold out_ready=0 from cycle 3 to cycle 12, then release.
  - in_ready=0 while output is held.
  - All 8 results appear in order, each correct, with none lost or duplicated.
- Reset mid-operation: 3 operations in flight, pulse rst low for 1 cycle -> out_valid=0 immediately (asynchronous), and no stale result appears afterwards.
